// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the parameter sanity check used at elaboration time.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand width must split into a whole number of digits.
  function automatic bit width_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/rca_digit.sv
// Combinational DIGIT-bit ripple-carry slice. Also exposes the carry into
// the slice MSB so the caller can derive signed overflow on the top digit.
module rca_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_s,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  // One full-adder cell per bit, carry rippling upward.
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB digit first,
// over WIDTH/DIGIT RUN cycles, then presents the result with a done pulse.
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  generate
    if (!width_ok(WIDTH, DIGIT)) begin : g_param_check
      $error("serial_adder_n: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic             w_capture;
  logic             w_run;
  logic             w_last;

  // Operand shift registers; b is stored already inverted for subtraction.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_ds;
  logic             w_dcout;
  logic             w_dcmsb;

  rca_digit #(
    .DIGIT (DIGIT)
  ) u_rca_digit (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_s    (w_ds),
    .o_cout (w_dcout),
    .o_cmsb (w_dcmsb)
  );

  // New digit enters at the top; after N cycles digit 0 sits at the bottom.
  generate
    if (N == 1) begin : g_acc_single
      assign w_acc_next = w_ds;
    end else begin : g_acc_shift
      assign w_acc_next = {w_ds, r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode; start is only looked at in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_run        = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture, per-digit shifting and carry/count bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_capture) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_dcout;
      r_cnt   <= r_cnt + 1'b1;
      r_acc   <= w_acc_next;
    end
  end

  // Result registers load only when the last digit completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_acc_next;
      r_cout <= w_dcout;
      r_ovf  <= w_dcout ^ w_dcmsb;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
